// File: rtl/csr_regfile_if.sv
// csr_regfile_if: CSR read/write port shared by the pipeline and the CSR storage.
//   csr_rnum  [13:0]  read CSR number
//   csr_rdata [31:0]  read data, combinational
//   csr_we            write enable
//   csr_wnum  [13:0]  write CSR number
//   csr_wdata [31:0]  write data, already field-masked
// master: pipeline side; slave: the register file.
interface csr_regfile_if;
  logic [13:0] csr_rnum;
  logic [31:0] csr_rdata;
  logic        csr_we;
  logic [13:0] csr_wnum;
  logic [31:0] csr_wdata;

  modport master (output csr_rnum, csr_we, csr_wnum, csr_wdata, input csr_rdata);
  modport slave  (input csr_rnum, csr_we, csr_wnum, csr_wdata, output csr_rdata);
endinterface

// File: rtl/csr_regfile.sv
// csr_regfile: architectural CSR storage. It accepts one CSR write per cycle, applies the
// side effects of exception entry and ertn, runs the constant timer and raises has_int.
//   clk, reset     clock; asynchronous active-high reset
//   bus            CSR read/write port (slave)
//   ex_*           exception commit: ecode, subcode, pc, and an optional bad virtual address
//   ertn_valid     ertn commit
//   hw_int[7:0]    level-sensitive external interrupt lines
//   ex_entry       EENTRY value
//   ertn_pc        ERA value
//   crmd_plv       CRMD.PLV value
//   has_int        an enabled interrupt is pending
module csr_regfile #(
  parameter int TIMER_WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  csr_regfile_if.slave        bus,
  input  logic                ex_valid,
  input  logic [5:0]          ex_ecode,
  input  logic [8:0]          ex_esubcode,
  input  logic [31:0]         ex_pc,
  input  logic                ex_badv_valid,
  input  logic [31:0]         ex_badv,
  input  logic                ertn_valid,
  input  logic [7:0]          hw_int,
  output logic [31:0]         ex_entry,
  output logic [31:0]         ertn_pc,
  output logic [1:0]          crmd_plv,
  output logic                has_int
);
  localparam logic [13:0] A_CRMD = 14'h00, A_PRMD = 14'h01, A_ECFG = 14'h04, A_ESTAT = 14'h05;
  localparam logic [13:0] A_ERA = 14'h06, A_BADV = 14'h07, A_EENTRY = 14'h0C;
  localparam logic [13:0] A_SAVE0 = 14'h30, A_SAVE1 = 14'h31, A_SAVE2 = 14'h32, A_SAVE3 = 14'h33;
  localparam logic [13:0] A_TID = 14'h40, A_TCFG = 14'h41, A_TVAL = 14'h42, A_TICLR = 14'h44;
  localparam logic [TIMER_WIDTH-1:0] TV_ONE = TIMER_WIDTH'(1);

  logic [8:0]             crmd;
  logic [2:0]             prmd;
  logic [12:0]            ecfg;
  logic [1:0]             is_sw;
  logic [7:0]             is_hw;
  logic                   is_timer;
  logic [5:0]             ecode;
  logic [8:0]             esubcode;
  logic [31:0]            era, badv, eentry, tid;
  logic [31:0]            save [4];
  logic [TIMER_WIDTH-1:0] tcfg, tval, tval_next;
  logic                   wr_en, timer_fire, ticlr_hit;
  logic [12:0]            is_all;
  logic [31:0]            estat, rdata;

  // Exception and ertn commits both pre-empt a WB-stage CSR write in the same cycle.
  assign wr_en     = bus.csr_we & ~ex_valid & ~ertn_valid;
  assign ticlr_hit = wr_en && bus.csr_wnum == A_TICLR && bus.csr_wdata[0];
  assign is_all    = {1'b0, is_timer, 1'b0, is_hw, is_sw};
  assign estat     = {1'b0, esubcode, ecode, 4'b0000, is_all[11:0]};

  // Down-counter: 1->0 raises the timer flag; in periodic mode the reload happens on the
  // cycle after reaching 0, so software sees TVAL==0 for one cycle.
  always_comb begin
    tval_next  = tval;
    timer_fire = 1'b0;
    if (wr_en && bus.csr_wnum == A_TCFG && bus.csr_wdata[0]) begin
      tval_next = {bus.csr_wdata[TIMER_WIDTH-1:2], 2'b00};
    end else if (tcfg[0]) begin
      if (tval != '0) begin
        tval_next  = tval - TV_ONE;
        timer_fire = (tval == TV_ONE);
      end else if (tcfg[1]) begin
        tval_next = {tcfg[TIMER_WIDTH-1:2], 2'b00};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crmd     <= 9'h008;
      prmd     <= '0;
      ecfg     <= '0;
      is_sw    <= '0;
      is_hw    <= '0;
      is_timer <= 1'b0;
      ecode    <= '0;
      esubcode <= '0;
      era      <= '0;
      badv     <= '0;
      eentry   <= '0;
      tid      <= '0;
      save[0]  <= '0;
      save[1]  <= '0;
      save[2]  <= '0;
      save[3]  <= '0;
      tcfg     <= '0;
      tval     <= '0;
    end else begin
      is_hw <= hw_int;
      tval  <= tval_next;
      if (timer_fire)     is_timer <= 1'b1;
      else if (ticlr_hit) is_timer <= 1'b0;

      if (ex_valid) begin
        prmd      <= crmd[2:0];
        crmd[2:0] <= 3'b000;
        era       <= ex_pc;
        ecode     <= ex_ecode;
        esubcode  <= ex_esubcode;
        if (ex_badv_valid) badv <= ex_badv;
      end else if (ertn_valid) begin
        crmd[2:0] <= prmd;
      end else if (wr_en) begin
        case (bus.csr_wnum)
          A_CRMD:   crmd   <= bus.csr_wdata[8:0];
          A_PRMD:   prmd   <= bus.csr_wdata[2:0];
          A_ECFG:   ecfg   <= bus.csr_wdata[12:0];
          A_ESTAT:  is_sw  <= bus.csr_wdata[1:0];
          A_ERA:    era    <= bus.csr_wdata;
          A_BADV:   badv   <= bus.csr_wdata;
          A_EENTRY: eentry <= bus.csr_wdata;
          A_SAVE0, A_SAVE1, A_SAVE2, A_SAVE3: save[bus.csr_wnum[1:0]] <= bus.csr_wdata;
          A_TID:    tid    <= bus.csr_wdata;
          A_TCFG:   tcfg   <= bus.csr_wdata[TIMER_WIDTH-1:0];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (bus.csr_rnum)
      A_CRMD:   rdata = {23'b0, crmd};
      A_PRMD:   rdata = {29'b0, prmd};
      A_ECFG:   rdata = {19'b0, ecfg};
      A_ESTAT:  rdata = estat;
      A_ERA:    rdata = era;
      A_BADV:   rdata = badv;
      A_EENTRY: rdata = eentry;
      A_SAVE0, A_SAVE1, A_SAVE2, A_SAVE3: rdata = save[bus.csr_rnum[1:0]];
      A_TID:    rdata = tid;
      A_TCFG:   rdata = 32'(tcfg);
      A_TVAL:   rdata = 32'(tval);
      default:  rdata = '0;
    endcase
  end

  assign bus.csr_rdata = rdata;
  assign ex_entry      = eentry;
  assign ertn_pc       = era;
  assign crmd_plv      = crmd[1:0];
  assign has_int       = crmd[2] & |(is_all & ecfg);
endmodule

// File: tb/tb_csr_regfile.sv
module tb_csr_regfile;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ex_valid = 1'b0;
  logic [5:0]  ex_ecode = '0;
  logic [8:0]  ex_esubcode = '0;
  logic [31:0] ex_pc = '0;
  logic        ex_badv_valid = 1'b0;
  logic [31:0] ex_badv = '0;
  logic        ertn_valid = 1'b0;
  logic [7:0]  hw_int = '0;
  logic [31:0] ex_entry, ertn_pc;
  logic [1:0]  crmd_plv;
  logic        has_int;
  int          errors = 0;
  int          checks = 0;

  csr_regfile_if bus ();

  csr_regfile #(.TIMER_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .ex_valid(ex_valid), .ex_ecode(ex_ecode), .ex_esubcode(ex_esubcode), .ex_pc(ex_pc),
    .ex_badv_valid(ex_badv_valid), .ex_badv(ex_badv), .ertn_valid(ertn_valid), .hw_int(hw_int),
    .ex_entry(ex_entry), .ertn_pc(ertn_pc), .crmd_plv(crmd_plv), .has_int(has_int)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [13:0] a, input logic [31:0] exp);
    bus.csr_rnum = a;
    #1;
    chk(tag, bus.csr_rdata, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [13:0] a, input logic [31:0] d);
    bus.csr_we = 1'b1;
    bus.csr_wnum = a;
    bus.csr_wdata = d;
    tick();
    bus.csr_we = 1'b0;
  endtask

  initial begin
    bus.csr_rnum = '0;
    bus.csr_we = 1'b0;
    bus.csr_wnum = '0;
    bus.csr_wdata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // reset values
    rd("rst_crmd", 14'h00, 32'h8);
    rd("rst_estat", 14'h05, 32'h0);
    rd("rst_tval", 14'h42, 32'h0);
    chk("rst_has_int", {31'b0, has_int}, 32'h0);

    // plain storage, unmapped, TICLR
    wr(14'h32, 32'hDEADBEEF);
    rd("save2", 14'h32, 32'hDEADBEEF);
    wr(14'h10, 32'h1234);
    rd("unmapped", 14'h10, 32'h0);
    wr(14'h44, 32'hFFFF_FFFE);
    rd("ticlr_rd", 14'h44, 32'h0);

    wr(14'h00, 32'h7);
    rd("crmd_wr", 14'h00, 32'h7);
    chk("plv_wr", {30'b0, crmd_plv}, 32'h3);
    wr(14'h0C, 32'h1C008000);
    chk("ex_entry", ex_entry, 32'h1C008000);
    wr(14'h07, 32'h1111);

    // exception with a simultaneous SAVE0 write (write dropped)
    ex_valid = 1'b1; ex_pc = 32'h1C000100; ex_ecode = 6'hB; ex_esubcode = 9'h0;
    ex_badv_valid = 1'b0; ex_badv = 32'hAAAA;
    bus.csr_we = 1'b1; bus.csr_wnum = 14'h30; bus.csr_wdata = 32'h55;
    tick();
    ex_valid = 1'b0; bus.csr_we = 1'b0;
    rd("ex_prmd", 14'h01, 32'h7);
    rd("ex_crmd", 14'h00, 32'h0);
    rd("ex_era", 14'h06, 32'h1C000100);
    rd("ex_estat", 14'h05, 32'h000B0000);
    rd("ex_badv_keep", 14'h07, 32'h1111);
    rd("ex_save0", 14'h30, 32'h0);
    chk("ertn_pc", ertn_pc, 32'h1C000100);

    // ertn beats a CRMD write in the same cycle
    ertn_valid = 1'b1;
    bus.csr_we = 1'b1; bus.csr_wnum = 14'h00; bus.csr_wdata = 32'h3;
    tick();
    ertn_valid = 1'b0; bus.csr_we = 1'b0;
    rd("ertn_crmd", 14'h00, 32'h7);
    chk("ertn_plv", {30'b0, crmd_plv}, 32'h3);

    // exception with a valid bad address and a subcode
    ex_valid = 1'b1; ex_pc = 32'h1C000200; ex_ecode = 6'h9; ex_esubcode = 9'h1;
    ex_badv_valid = 1'b1; ex_badv = 32'h000BADD0;
    tick();
    ex_valid = 1'b0; ex_badv_valid = 1'b0;
    rd("ex2_badv", 14'h07, 32'h000BADD0);
    rd("ex2_estat", 14'h05, 32'h00490000);

    // only IS[1:0] writable in ESTAT
    wr(14'h05, 32'hFFFFFFFF);
    rd("estat_sw", 14'h05, 32'h00490003);
    wr(14'h05, 32'h0);
    rd("estat_sw_clr", 14'h05, 32'h00490000);

    // periodic timer, InitVal=1
    wr(14'h41, 32'h7);
    rd("tcfg", 14'h41, 32'h7);
    rd("per_t4", 14'h42, 32'h4);
    tick(); rd("per_t3", 14'h42, 32'h3);
    tick(); rd("per_t2", 14'h42, 32'h2);
    tick(); rd("per_t1", 14'h42, 32'h1);
    rd("per_noflag", 14'h05, 32'h00490000);
    tick(); rd("per_t0", 14'h42, 32'h0);
    rd("per_flag", 14'h05, 32'h00490800);
    tick(); rd("per_reload", 14'h42, 32'h4);
    rd("per_flag_hold", 14'h05, 32'h00490800);
    wr(14'h44, 32'h1);
    rd("per_ticlr", 14'h05, 32'h00490000);
    rd("per_t3b", 14'h42, 32'h3);
    wr(14'h41, 32'h0);
    rd("dis_t2", 14'h42, 32'h2);
    tick(); rd("dis_frozen", 14'h42, 32'h2);

    // one-shot timer with TICLR on the firing edge
    wr(14'h41, 32'h5);
    rd("os_t4", 14'h42, 32'h4);
    tick(); tick(); tick();
    rd("os_t1", 14'h42, 32'h1);
    wr(14'h44, 32'h1);
    rd("os_set_wins", 14'h05, 32'h00490800);
    rd("os_t0", 14'h42, 32'h0);
    tick(); rd("os_hold0", 14'h42, 32'h0);
    wr(14'h44, 32'h1);
    rd("os_ticlr", 14'h05, 32'h00490000);
    tick(); rd("os_no_refire", 14'h05, 32'h00490000);
    rd("os_hold0b", 14'h42, 32'h0);

    // interrupt from hw_int[0]
    wr(14'h41, 32'h0);
    wr(14'h04, 32'h4);
    wr(14'h00, 32'h4);
    chk("int_idle", {31'b0, has_int}, 32'h0);
    hw_int = 8'h01;
    #1 chk("int_unreg", {31'b0, has_int}, 32'h0);
    tick(); tick();
    chk("int_set", {31'b0, has_int}, 32'h1);
    rd("int_estat", 14'h05, 32'h00490004);
    wr(14'h00, 32'h0);
    chk("int_ie_off", {31'b0, has_int}, 32'h0);

    // reset in the middle of a countdown
    wr(14'h41, 32'h41);
    tick(); tick();
    rd("mid_tval", 14'h42, 32'h3E);
    #2 reset = 1'b1;
    rd("arst_tval", 14'h42, 32'h0);
    rd("arst_crmd", 14'h00, 32'h8);
    rd("arst_tcfg", 14'h41, 32'h0);
    rd("arst_estat", 14'h05, 32'h0);
    chk("arst_era", ertn_pc, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    tick();
    rd("post_tval", 14'h42, 32'h0);
    rd("post_estat", 14'h05, 32'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
